rename_table: RTL and testbench

Register alias table and physical-register free list answering the resolver's two `reg_query_bus_if` queries per cycle. Each cycle it translates architectural sources to physical IDs and allocates a fresh physical ID for every renaming destination. It recycles IDs freed by retirement, and checkpoints and restores state around one level of speculation (tag). It sits between the resolver and the reservation stations/ROB and raises `stop_out` when it cannot guarantee two allocations.

---
 rtl/rename_table_pkg.sv | 9 +
 rtl/rename_table_free_list.sv | 60 ++++++
 rtl/rename_table.sv | 100 ++++++++++
 tb/tb_rename_table.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/rename_table_pkg.sv
// rename_table_pkg: shared types and sizes for the register alias table and free list.
package rename_table_pkg;
    localparam int ARCH_REGS       = 32;
    localparam int FREE_LIST_DEPTH = 32;
    typedef logic [5:0] phys_reg_t;
    typedef logic [4:0] arch_reg_t;
    typedef logic [4:0] fl_ptr_t;
    typedef logic [5:0] fl_count_t;
endpackage

// File: rtl/rename_table_free_list.sv
// free_list: circular FIFO of free physical IDs with two pops, two pushes and head restore.
// Ports: clk/rst; pops = number of IDs consumed this edge; push_k/push_id_k return IDs
// (ID 0 is dropped); restore/restore_head rewind the head; head_id_0/1 are the next two
// free IDs; head and count expose pointer state; stop is registered (count after edge < 2).
module free_list
    import rename_table_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] pops,
    input  logic       push_0,
    input  phys_reg_t  push_id_0,
    input  logic       push_1,
    input  phys_reg_t  push_id_1,
    input  logic       restore,
    input  fl_ptr_t    restore_head,
    output phys_reg_t  head_id_0,
    output phys_reg_t  head_id_1,
    output fl_ptr_t    head,
    output fl_count_t  count,
    output logic       stop
);
    localparam fl_count_t FULL = fl_count_t'(FREE_LIST_DEPTH);
    phys_reg_t entries [FREE_LIST_DEPTH];
    fl_ptr_t   tail, head_next, tail_next, diff;
    fl_count_t after_pop, count_next;
    logic      acc_0, acc_1;
    assign head_id_0 = entries[head];
    assign head_id_1 = entries[head + 5'd1];
    always_comb begin
        after_pop  = count - fl_count_t'(pops);
        acc_0      = push_0 && push_id_0 != '0 && after_pop < FULL;
        acc_1      = push_1 && push_id_1 != '0 && (after_pop + fl_count_t'(acc_0)) < FULL;
        tail_next  = tail + fl_ptr_t'(acc_0) + fl_ptr_t'(acc_1);
        head_next  = restore ? restore_head : head + fl_ptr_t'(pops);
        diff       = tail_next - head_next;
        // A restored head always leaves at least one speculative ID free, so equal
        // pointers after a rollback mean a full list, never an empty one.
        count_next = restore ? (diff == '0 ? FULL : fl_count_t'(diff))
                             : after_pop + fl_count_t'(acc_0) + fl_count_t'(acc_1);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FREE_LIST_DEPTH; i++) entries[i] <= phys_reg_t'(FREE_LIST_DEPTH + i);
            head  <= '0;
            tail  <= '0;
            count <= FULL;
            stop  <= 1'b0;
        end else begin
            if (acc_0) entries[tail] <= push_id_0;
            if (acc_1) entries[tail + fl_ptr_t'(acc_0)] <= push_id_1;
            head  <= head_next;
            tail  <= tail_next;
            count <= count_next;
            stop  <= count_next < 6'd2;
            assert (!(push_0 && push_id_0 != '0 && !acc_0) && !(push_1 && push_id_1 != '0 && !acc_1))
                else $error("free_list: push dropped on full list");
        end
    end
endmodule

// File: rtl/rename_table.sv
// rename_table: register alias table plus free list serving two rename queries per cycle.
// Ports: clk/rst; delete_tagged rolls back to the checkpoint, clear_tags drops it;
// qK_rs_1/qK_rs_2/qK_rd/qK_rename/qK_tag are query K inputs, qK_rs_1_id/qK_rs_2_id are the
// mapped sources and qK_rn the allocated ID; free_valid_k/free_rn_k return retired IDs;
// stop_out (registered) tells the resolver fewer than two IDs remain.
module rename_table
    import rename_table_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      delete_tagged,
    input  logic      clear_tags,
    input  arch_reg_t q0_rs_1,
    input  arch_reg_t q0_rs_2,
    input  arch_reg_t q0_rd,
    input  logic      q0_rename,
    input  logic      q0_tag,
    output phys_reg_t q0_rs_1_id,
    output phys_reg_t q0_rs_2_id,
    output phys_reg_t q0_rn,
    input  arch_reg_t q1_rs_1,
    input  arch_reg_t q1_rs_2,
    input  arch_reg_t q1_rd,
    input  logic      q1_rename,
    input  logic      q1_tag,
    output phys_reg_t q1_rs_1_id,
    output phys_reg_t q1_rs_2_id,
    output phys_reg_t q1_rn,
    input  logic      free_valid_0,
    input  phys_reg_t free_rn_0,
    input  logic      free_valid_1,
    input  phys_reg_t free_rn_1,
    output logic      stop_out
);
    phys_reg_t  map      [ARCH_REGS];
    phys_reg_t  ckpt_map [ARCH_REGS];
    fl_ptr_t    head, ckpt_head;
    fl_count_t  count;
    phys_reg_t  head_id_0, head_id_1;
    logic       ckpt_valid, want_0, want_1, alloc_0, alloc_1, restore, take_ckpt;
    logic [1:0] pops;
    assign q0_rs_1_id = map[q0_rs_1];
    assign q0_rs_2_id = map[q0_rs_2];
    assign q1_rs_1_id = map[q1_rs_1];
    assign q1_rs_2_id = map[q1_rs_2];
    always_comb begin
        want_0    = q0_rename && q0_rd != '0;
        want_1    = q1_rename && q1_rd != '0;
        // A rollback cycle ignores queries; an empty list refuses the allocation.
        alloc_0   = !delete_tagged && want_0 && count != '0;
        alloc_1   = !delete_tagged && want_1 && count >= (alloc_0 ? 6'd2 : 6'd1);
        pops      = {1'b0, alloc_0} + {1'b0, alloc_1};
        restore   = delete_tagged && ckpt_valid;
        take_ckpt = !ckpt_valid && !clear_tags && ((alloc_0 && q0_tag) || (alloc_1 && q1_tag));
        q0_rn     = (q0_rename && !alloc_0) ? '0 : head_id_0;
        q1_rn     = (q1_rename && !alloc_1) ? '0 : (alloc_0 ? head_id_1 : head_id_0);
    end
    free_list u_free_list (
        .clk          (clk),
        .rst          (rst),
        .pops         (pops),
        .push_0       (free_valid_0),
        .push_id_0    (free_rn_0),
        .push_1       (free_valid_1),
        .push_id_1    (free_rn_1),
        .restore      (restore),
        .restore_head (ckpt_head),
        .head_id_0    (head_id_0),
        .head_id_1    (head_id_1),
        .head         (head),
        .count        (count),
        .stop         (stop_out)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                map[i]      <= phys_reg_t'(i);
                ckpt_map[i] <= phys_reg_t'(i);
            end
            ckpt_head  <= '0;
            ckpt_valid <= 1'b0;
        end else if (restore) begin
            map        <= ckpt_map;
            ckpt_valid <= 1'b0;
        end else begin
            if (clear_tags || delete_tagged) begin
                ckpt_valid <= 1'b0;
            end else if (take_ckpt) begin
                ckpt_valid <= 1'b1;
                ckpt_map   <= map;
                ckpt_head  <= head;
            end
            // Query 1 is written last so it wins when both rename the same register.
            if (alloc_0) map[q0_rd] <= q0_rn;
            if (alloc_1) map[q1_rd] <= q1_rn;
            assert (delete_tagged || (want_0 == alloc_0 && want_1 == alloc_1))
                else $error("rename_table: allocation requested with empty free list");
        end
    end
endmodule

// File: tb/tb_rename_table.sv
// tb_rename_table: scoreboard bench for rename_table with directed vectors.
module tb_rename_table;
    logic       clk, rst, delete_tagged, clear_tags;
    logic [4:0] q0_rs_1, q0_rs_2, q0_rd, q1_rs_1, q1_rs_2, q1_rd;
    logic       q0_rename, q0_tag, q1_rename, q1_tag;
    logic [5:0] q0_rs_1_id, q0_rs_2_id, q0_rn, q1_rs_1_id, q1_rs_2_id, q1_rn;
    logic       free_valid_0, free_valid_1, stop_out;
    logic [5:0] free_rn_0, free_rn_1;

    typedef enum {S_Q0_RS1, S_Q0_RS2, S_Q0_RN, S_Q1_RS1, S_Q1_RS2, S_Q1_RN, S_STOP, S_COUNT} sig_e;
    typedef struct {sig_e sig; int val; string name;} exp_t;
    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   failed = 0;
    int   got;

    rename_table dut (
        .clk(clk), .rst(rst), .delete_tagged(delete_tagged), .clear_tags(clear_tags),
        .q0_rs_1(q0_rs_1), .q0_rs_2(q0_rs_2), .q0_rd(q0_rd), .q0_rename(q0_rename), .q0_tag(q0_tag),
        .q0_rs_1_id(q0_rs_1_id), .q0_rs_2_id(q0_rs_2_id), .q0_rn(q0_rn),
        .q1_rs_1(q1_rs_1), .q1_rs_2(q1_rs_2), .q1_rd(q1_rd), .q1_rename(q1_rename), .q1_tag(q1_tag),
        .q1_rs_1_id(q1_rs_1_id), .q1_rs_2_id(q1_rs_2_id), .q1_rn(q1_rn),
        .free_valid_0(free_valid_0), .free_rn_0(free_rn_0),
        .free_valid_1(free_valid_1), .free_rn_1(free_rn_1), .stop_out(stop_out)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic int observe(sig_e s);
        case (s)
            S_Q0_RS1: return int'(q0_rs_1_id);
            S_Q0_RS2: return int'(q0_rs_2_id);
            S_Q0_RN:  return int'(q0_rn);
            S_Q1_RS1: return int'(q1_rs_1_id);
            S_Q1_RS2: return int'(q1_rs_2_id);
            S_Q1_RN:  return int'(q1_rn);
            S_STOP:   return int'(stop_out);
            default:  return int'(dut.u_free_list.count);
        endcase
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            got = observe(mon_e.sig);
            tests++;
            if (got != mon_e.val) begin
                failed++;
                $display("FAIL %s: got %0d expected %0d", mon_e.name, got, mon_e.val);
            end
        end
    end

    task automatic clear_inputs();
        delete_tagged = 0; clear_tags = 0;
        q0_rs_1 = 0; q0_rs_2 = 0; q0_rd = 0; q0_rename = 0; q0_tag = 0;
        q1_rs_1 = 0; q1_rs_2 = 0; q1_rd = 0; q1_rename = 0; q1_tag = 0;
        free_valid_0 = 0; free_rn_0 = 0; free_valid_1 = 0; free_rn_1 = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic do_reset();
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic expect_val(input sig_e s, input int v, input string n);
        sb.push_back('{s, v, n});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench did not complete");
    end

    initial begin
        rst = 1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        q0_rs_1 = 5; q0_rs_2 = 7;
        expect_val(S_Q0_RS1, 5, "reset lookup rs_1");
        expect_val(S_Q0_RS2, 7, "reset lookup rs_2");
        expect_val(S_Q1_RS1, 0, "reset lookup x0");
        expect_val(S_STOP, 0, "reset stop_out");
        expect_val(S_COUNT, 32, "reset count");
        step();
        q0_rd = 3; q0_rename = 1; q1_rd = 4; q1_rename = 1;
        expect_val(S_Q0_RN, 32, "pair alloc q0 rn");
        expect_val(S_Q1_RN, 33, "pair alloc q1 rn");
        step();
        q0_rs_1 = 3; q0_rs_2 = 4; q1_rs_1 = 5;
        expect_val(S_Q0_RS1, 32, "map[3] after alloc");
        expect_val(S_Q0_RS2, 33, "map[4] after alloc");
        expect_val(S_Q1_RS1, 5, "map[5] untouched");
        expect_val(S_COUNT, 30, "count after pair alloc");
        step();
        do_reset();
        q0_rd = 0; q0_rename = 1; q1_rd = 9; q1_rename = 1;
        expect_val(S_Q0_RN, 0, "rd=x0 rn");
        expect_val(S_Q1_RN, 32, "q1 takes head");
        step();
        q0_rs_1 = 0; q0_rs_2 = 9;
        q0_rd = 11; q0_rename = 1; q1_rd = 11; q1_rename = 1; q1_rs_1 = 11;
        expect_val(S_Q0_RS1, 0, "map[0] stays 0");
        expect_val(S_Q0_RS2, 32, "map[9]");
        expect_val(S_COUNT, 31, "count single alloc");
        expect_val(S_Q0_RN, 33, "same rd q0 rn");
        expect_val(S_Q1_RN, 34, "same rd q1 rn");
        expect_val(S_Q1_RS1, 11, "intra pair reads old map");
        step();
        q0_rs_1 = 11;
        expect_val(S_Q0_RS1, 34, "same rd q1 wins");
        expect_val(S_COUNT, 29, "count after same rd");
        step();
        do_reset();
        for (int k = 0; k < 15; k++) begin
            q0_rd = 1; q0_rename = 1; q1_rd = 2; q1_rename = 1;
            expect_val(S_Q0_RN, 32 + 2 * k, "drain q0 rn");
            expect_val(S_Q1_RN, 33 + 2 * k, "drain q1 rn");
            step();
        end
        q0_rd = 1; q0_rename = 1; q1_rd = 2; q1_rename = 1;
        expect_val(S_COUNT, 2, "count at two");
        expect_val(S_STOP, 0, "stop at two");
        expect_val(S_Q0_RN, 62, "last q0 rn");
        expect_val(S_Q1_RN, 63, "last q1 rn");
        step();
        q0_rs_1 = 1; q0_rs_2 = 2;
        free_valid_0 = 1; free_rn_0 = 50; free_valid_1 = 1; free_rn_1 = 45;
        expect_val(S_COUNT, 0, "count empty");
        expect_val(S_STOP, 1, "stop empty");
        expect_val(S_Q0_RS1, 62, "map[1] last");
        expect_val(S_Q0_RS2, 63, "map[2] last");
        step();
        q0_rd = 5; q0_rename = 1;
        free_valid_0 = 1; free_rn_0 = 60; free_valid_1 = 1; free_rn_1 = 0;
        expect_val(S_COUNT, 2, "count after free");
        expect_val(S_STOP, 0, "stop after free");
        expect_val(S_Q0_RN, 50, "wrapped head rn");
        step();
        q0_rs_1 = 5;
        q0_rd = 12; q0_rename = 1; q1_rd = 13; q1_rename = 1;
        expect_val(S_COUNT, 2, "alloc+free same cycle, id0 dropped");
        expect_val(S_STOP, 0, "stop alloc+free");
        expect_val(S_Q0_RS1, 50, "map[5] freed id");
        expect_val(S_Q0_RN, 45, "free order q0 rn");
        expect_val(S_Q1_RN, 60, "free order q1 rn");
        step();
        expect_val(S_COUNT, 0, "count empty again");
        expect_val(S_STOP, 1, "stop empty again");
        step();
        do_reset();
        q0_rd = 6; q0_rename = 1; q0_tag = 1;
        expect_val(S_Q0_RN, 32, "tagged alloc rn");
        step();
        delete_tagged = 1; q0_rs_1 = 6;
        expect_val(S_Q0_RS1, 32, "speculative map[6]");
        expect_val(S_COUNT, 31, "speculative count");
        step();
        q0_rs_1 = 6; q0_rd = 7; q0_rename = 1;
        expect_val(S_Q0_RS1, 6, "rollback map[6]");
        expect_val(S_COUNT, 32, "rollback count");
        expect_val(S_Q0_RN, 32, "reused id after rollback");
        step();
        q0_rs_1 = 7;
        expect_val(S_Q0_RS1, 32, "map[7] after rollback alloc");
        expect_val(S_COUNT, 31, "count after rollback alloc");
        step();
        do_reset();
        q0_rd = 6; q0_rename = 1; q0_tag = 1;
        expect_val(S_Q0_RN, 32, "tagged alloc before clear");
        step();
        clear_tags = 1;
        step();
        delete_tagged = 1;
        step();
        q0_rs_1 = 6;
        expect_val(S_Q0_RS1, 32, "clear_tags keeps map[6]");
        expect_val(S_COUNT, 31, "clear_tags keeps count");
        step();
        q0_rd = 6; q0_rename = 1; q0_tag = 1;
        step();
        do_reset();
        q0_rd = 8; q0_rename = 1; q0_rs_1 = 6;
        expect_val(S_Q0_RN, 32, "alloc after mid-spec reset");
        expect_val(S_Q0_RS1, 6, "reset discards spec map");
        step();
        delete_tagged = 1;
        step();
        q0_rs_1 = 8;
        expect_val(S_Q0_RS1, 32, "no rollback after reset");
        expect_val(S_COUNT, 31, "count no rollback after reset");
        step();
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            tests++;
            failed++;
            $display("FAIL scoreboard drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
